// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with IDLE / RUN / HALTED control.
// Start launches execution from START_ADDR. Halt ends it, Stall freezes the
// PC, and BranchTaken redirects the PC with one cycle of latency.
// CycleCount counts fetch cycles since the last Start and saturates at its maximum.
// Optional feature macro: BR_RELATIVE_EN. When it is defined, a taken branch
// adds Target to the PC as a signed offset. By default, a taken branch loads
// Target as an absolute address.
// Reset is synchronous and active high.

module pc_sequencer #(
  parameter int             D          = 12,
  parameter logic [D-1:0]   START_ADDR = '0,
  parameter int             CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [D-1:0]     Target,
  output logic [D-1:0]     ProgCtr,
  output logic             Fetch,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  logic [D-1:0]     pc_inc;
  logic [D-1:0]     br_pc;
  logic [CNT_W-1:0] cnt_inc;

  // Handshake: Fetch is a per-cycle consume strobe with no back-pressure.
  // While Fetch=1, the instruction at ProgCtr is taken on the next rising edge.
  // Start is a single-cycle request. It is honoured only in IDLE or HALTED.
  assign Fetch     = (state == RUN) & ~Halt & ~Stall;
  assign state_dbg = state;

  // Sequential successor of the PC. Addition is modulo 2^D, so the top address wraps to 0.
  assign pc_inc = ProgCtr + {{(D-1){1'b0}}, 1'b1};

`ifdef BR_RELATIVE_EN
  // Relative branch: Target is a two's-complement offset, and the sum wraps at 2^D.
  assign br_pc = ProgCtr + Target;
`else
  // Absolute branch: Target goes straight to the PC, with no adder on this path.
  assign br_pc = Target;
`endif

  // Saturating increment: the counter sticks at all-ones and never wraps.
  always_comb begin
    cnt_inc = CycleCount;
    if (CycleCount != {CNT_W{1'b1}}) begin
      cnt_inc = CycleCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM: owns the state, the PC, the cycle counter and the registered Done flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= START_ADDR;
      CycleCount <= '0;
      Done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state      <= RUN;
            ProgCtr    <= START_ADDR;
            CycleCount <= '0;
          end
        end
        RUN: begin
          // Priority in RUN: Halt, then Stall, then branch, then sequential. Start is ignored here.
          if (Halt) begin
            state <= HALTED;
            Done  <= 1'b1;
          end else if (!Stall) begin
            ProgCtr    <= BranchTaken ? br_pc : pc_inc;
            CycleCount <= cnt_inc;
          end
        end
        HALTED: begin
          if (Start) begin
            state      <= RUN;
            ProgCtr    <= START_ADDR;
            CycleCount <= '0;
            Done       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter D, default 12: program counter width in bits.
REQ-002 Parameter START_ADDR, default 0: PC value loaded on reset and on Start.
REQ-003 Parameter CNT_W, default 16: width of the executed-cycle counter.
REQ-004 Clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  single-cycle pulse that begins program execution.
REQ-007 Halt  input  1  decoded halt instruction; ends execution.
REQ-008 Stall  input  1  freeze PC for this cycle, e.g. on a memory wait.
REQ-009 BranchTaken  input  1  redirect the PC to a branch target this cycle.
REQ-010 Target  input  D  branch target value from the PC target lookup table; treated as two's complement in relative mode.
REQ-011 ProgCtr  output  D  current program counter, registered.
REQ-012 Fetch  output  1  instruction at ProgCtr is consumed this cycle.
REQ-013 Done  output  1  registered; high while in HALTED.
REQ-014 CycleCount  output  CNT_W  number of Fetch cycles since the last Start, registered.

Function
REQ-015 The block SHALL implement the FSM states IDLE, RUN and HALTED.
REQ-016 IDLE: Start=1 -> RUN, ProgCtr<=START_ADDR, CycleCount<=0; otherwise stay in IDLE with ProgCtr held.
REQ-017 RUN: per-cycle priority SHALL be Halt > Stall > BranchTaken > sequential increment.
REQ-018 RUN, Halt=1: next state HALTED; ProgCtr and CycleCount held, even if Stall or BranchTaken is also set.
REQ-019 RUN, Stall=1 and Halt=0: ProgCtr and CycleCount held; state stays RUN.
REQ-020 RUN, BranchTaken=1 and neither Halt nor Stall: ProgCtr SHALL take the branch update defined in REQ-030/REQ-031.
REQ-021 RUN with Halt, Stall and BranchTaken all 0: ProgCtr<=(ProgCtr+1) mod 2^D; 2^D-1 wraps to 0.
REQ-022 Fetch SHALL be combinational, equal to (state==RUN) & ~Halt & ~Stall.
REQ-023 CycleCount SHALL increment by 1 on every cycle where Fetch=1.
REQ-024 CycleCount SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 HALTED: Done=1; ProgCtr and CycleCount held.
REQ-026 HALTED, Start=1: next state RUN, ProgCtr<=START_ADDR, CycleCount<=0, and Done falls on the same edge.
REQ-027 Start while in RUN SHALL be ignored.
REQ-028 Start in IDLE or HALTED SHALL override Halt, Stall and BranchTaken in that cycle.
REQ-029 Redirect latency SHALL be one cycle: the new ProgCtr is visible the cycle after BranchTaken is sampled.

Configuration
REQ-030 With BR_RELATIVE_EN defined, a taken branch SHALL set ProgCtr<=(ProgCtr+Target) mod 2^D, with Target read as signed D-bit.
  - Target=0 holds the PC (self-loop).
  - Target=2^D-1 steps back 1.
REQ-031 With BR_RELATIVE_EN undefined, a taken branch SHALL set ProgCtr<=Target (absolute), with no adder on the branch path.

Reset
REQ-032 Reset=1 at a rising edge SHALL, with priority over all other inputs and from any state (including mid-RUN), set:
  - state<=IDLE
  - ProgCtr<=START_ADDR
  - CycleCount<=0
  - Done<=0
REQ-033 While Reset=1, Fetch SHALL be 0 from the first post-reset cycle onward.

Verification
REQ-034 Reset held 2 cycles, then Start pulse, then 5 idle cycles -> ProgCtr 0,1,2,3,4,5; Fetch=1 each RUN cycle; CycleCount=5.
REQ-035 BR_RELATIVE_EN defined, ProgCtr=4:
  - BranchTaken with Target=0xFFF -> ProgCtr=3.
  - BranchTaken with Target=0x014 -> ProgCtr=24.
  - BranchTaken with Target=0x000 -> ProgCtr stays 4 with Fetch=1.
REQ-036 BR_RELATIVE_EN undefined, ProgCtr=4, BranchTaken with Target=20 -> ProgCtr=20; ProgCtr=0xFFF with no branch -> ProgCtr=0 (wrap).
REQ-037 Overlapping inputs:
  - Stall and BranchTaken together at ProgCtr=7 -> ProgCtr stays 7 and CycleCount is unchanged.
  - Halt, Stall and BranchTaken together -> HALTED with Done=1 next cycle and ProgCtr held.
REQ-038 Start from HALTED -> RUN, ProgCtr=0, CycleCount=0, Done=0.
REQ-039 Reset asserted mid-RUN at ProgCtr=9 -> IDLE, ProgCtr=0, Done=0.
REQ-040 With CNT_W=4, run more than 15 Fetch cycles -> CycleCount saturates at 15.
